debounce_edge: RTL and testbench
================================

Name: debounce_edge

Overview:
- Input-conditioning stage that sits directly upstream of the team's dff cell.
- Takes a raw, asynchronous, possibly bouncing level `din` and synchronizes it into `clk`.
- Filters glitches shorter than a programmable stability window, then drives a clean level `dout` (and `dout_bar`) suitable for the dff `d` input.
- Also emits one-cycle rise/fall pulses and a saturating edge counter for bench and debug use.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on `din`; legal range 2..4.
- STABLE_CNT, 4, consecutive enabled cycles the synchronized input must differ from `dout` before `dout` changes; legal range 1..255.
- CNT_W, 8, width of `edge_cnt`.
- RESET_VAL, 1'b0, reset value of the synchronizer chain and `dout`.

Ports:
- clk, input, 1, single clock; all state updates on its rising edge.
- rst, input, 1, asynchronous, active-low reset; asserting it (0) immediately forces all state to reset values.
- en, input, 1, filter enable; when 0, filter state freezes.
- din, input, 1, raw asynchronous level.
- cnt_clr, input, 1, synchronous clear of `edge_cnt`.
- dout, output, 1, debounced level.
- dout_bar, output, 1, always `~dout`.
- rise, output, 1, one-cycle pulse on a 0->1 change of `dout`.
- fall, output, 1, one-cycle pulse on a 1->0 change of `dout`.
- busy, output, 1, high while in the VERIFY state.
- edge_cnt, output, CNT_W, count of `dout` transitions.

Behaviour:
- Reset (`rst`=0, asynchronous):
  - sync chain = RESET_VAL, `dout` = RESET_VAL, `dout_bar` = ~RESET_VAL.
  - `rise` = `fall` = 0, `busy` = 0, `edge_cnt` = 0, timer = 0, state = STABLE.
  - Deassertion takes effect on the next `clk` edge.
- Synchronizer:
  - `din` passes through a SYNC_STAGES flop chain that runs every cycle regardless of `en`.
  - `s` is the last stage of the chain.
- FSM, two states: STABLE and VERIFY.
  - STABLE: if `en`=1 and `s`!=`dout`, set timer = 1. If STABLE_CNT==1, `dout` toggles on this same edge and the state stays STABLE. Otherwise go to VERIFY.
  - VERIFY with `en`=1 and `s`==`dout`: glitch rejected. Return to STABLE, timer = 0, no output change.
  - VERIFY with `en`=1 and `s`!=`dout`: timer += 1. When the timer reaches STABLE_CNT, toggle `dout`, timer = 0, go to STABLE.
  - VERIFY with `en`=0: state and timer hold; no toggle.
  - `busy` = (state == VERIFY), registered.
- Latency: a clean `din` step reaches `dout` SYNC_STAGES + STABLE_CNT rising edges after the first edge that samples the new value. This is 6 edges at the defaults.
- Pulses:
  - `rise`/`fall` are registered and go high for exactly one cycle on the edge where `dout` changes.
  - They are never both high.
  - Both are 0 whenever `en`=0.
- `edge_cnt`:
  - +1 on each `dout` toggle; saturates at 2^CNT_W-1 (no wrap).
  - `cnt_clr`=1 forces 0 and takes priority over a same-cycle increment. `dout` and the pulses are unaffected.
- Width rule: the timer is 8 bits wide; compare it to STABLE_CNT at full width.
- Glitch rule: any `s` pulse shorter than STABLE_CNT enabled cycles never changes `dout`.
- Reset mid-VERIFY: the pending change is discarded and the state returns to STABLE/RESET_VAL with no pulse.

Test Plan:
- Reset value: hold `rst`=0, `din`=1, toggle `clk` for 5 edges -> `dout`=0, `dout_bar`=1, `edge_cnt`=0, `busy`=0. Release `rst`, `en`=1 -> `dout`=1 at edge 6 after release, `rise`=1 for one cycle, `edge_cnt`=1.
- Glitch rejection: `dout`=0; drive `din`=1 for 3 cycles then 0 -> `busy` pulses, `dout` stays 0, no `rise`, `edge_cnt` unchanged. Drive `din`=1 for 4+ cycles -> `dout`=1 exactly 6 edges after first sample.
- Enable freeze: `din` 0->1, drop `en` after 2 VERIFY cycles for 10 cycles -> `busy` stays 1, `dout`=0. Restore `en` -> `dout`=1 after 2 more cycles, `rise` asserted.
- Toggle train (period 2 ns, `din` flips every 8 ns) with STABLE_CNT=2 -> alternating `rise`/`fall`, `edge_cnt` increments per flip. Set CNT_W=2 -> saturates at 3. `cnt_clr`=1 on an increment cycle -> `edge_cnt`=0.
- Reset mid-operation: assert `rst` low for 1 ns while `busy`=1 -> outputs return to reset values immediately (asynchronously), no `fall`/`rise`, state STABLE.
- STABLE_CNT=1 -> `dout` follows `din` with exactly SYNC_STAGES+1 edges latency; `busy` never asserts.

Source files
------------

// File: rtl/debounce_edge.sv
// debounce_edge: synchronizes a raw asynchronous level into clk_i and filters glitches.
// The synchronized level must differ from dout_o for STABLE_CNT consecutive enabled
// cycles before dout_o follows it. Also produces rise/fall pulses and a saturating
// count of dout_o transitions.
//
// Ports:
//   clk_i       single clock, rising edge
//   rst_ni      asynchronous active-low reset
//   en_i        filter enable; 0 freezes the filter (the synchronizer keeps running)
//   din_i       raw asynchronous input level
//   cnt_clr_i   synchronous clear of edge_cnt_o; wins over a same-cycle increment
//   dout_o      debounced level
//   dout_bar_o  ~dout_o
//   rise_o      one-cycle pulse after a 0->1 change of dout_o
//   fall_o      one-cycle pulse after a 1->0 change of dout_o
//   busy_o      high while a candidate change is being verified
//   edge_cnt_o  saturating count of dout_o transitions
module debounce_edge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned STABLE_CNT  = 4,
    parameter int unsigned CNT_W       = 8,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             din_i,
    input  logic             cnt_clr_i,
    output logic             dout_o,
    output logic             dout_bar_o,
    output logic             rise_o,
    output logic             fall_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] edge_cnt_o
);

    typedef enum logic [0:0] {
        StStable,
        StVerify
    } state_e;

    // Timer is always 8 bits; the window is compared at that full width.
    localparam logic [7:0]       StableCnt = 8'(STABLE_CNT);
    localparam logic [7:0]       TimerOne  = 8'd1;
    localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CntMax    = {CNT_W{1'b1}};

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    state_e           state_q, state_d;
    logic [7:0]       timer_q, timer_d;
    logic [7:0]       timer_inc;
    logic             dout_q, dout_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
    logic             toggle;

    // ------------------------------------------------------------------
    // Synchronizer: free-running, independent of en_i.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din_i};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Filter FSM: next state, timer and toggle decision.
    // ------------------------------------------------------------------
    assign timer_inc = timer_q + TimerOne;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        toggle  = 1'b0;

        unique case (state_q)
            StStable: begin
                if (en_i && (s != dout_q)) begin
                    if (StableCnt == TimerOne) begin
                        // Single-cycle window: the first differing sample is enough.
                        toggle  = 1'b1;
                        timer_d = '0;
                    end else begin
                        timer_d = TimerOne;
                        state_d = StVerify;
                    end
                end
            end

            StVerify: begin
                if (en_i) begin
                    if (s == dout_q) begin
                        // Input fell back before the window elapsed: glitch.
                        timer_d = '0;
                        state_d = StStable;
                    end else if (timer_inc == StableCnt) begin
                        toggle  = 1'b1;
                        timer_d = '0;
                        state_d = StStable;
                    end else begin
                        timer_d = timer_inc;
                    end
                end
            end

            default: begin
                timer_d = '0;
                state_d = StStable;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output level, pulses and transition counter.
    // ------------------------------------------------------------------
    always_comb begin
        dout_d = dout_q ^ toggle;
        rise_d = toggle & ~dout_q;
        fall_d = toggle & dout_q;

        edge_cnt_d = edge_cnt_q;
        if (cnt_clr_i) begin
            edge_cnt_d = '0;
        end else if (toggle && (edge_cnt_q != CntMax)) begin
            edge_cnt_d = edge_cnt_q + CntOne;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StStable;
            timer_q    <= '0;
            dout_q     <= RESET_VAL;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            edge_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            dout_q     <= dout_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            edge_cnt_q <= edge_cnt_d;
        end
    end

    assign dout_o     = dout_q;
    assign dout_bar_o = ~dout_q;
    // Pulses are masked by en_i so they read 0 whenever the filter is disabled,
    // even in the cycle right after a toggle.
    assign rise_o     = rise_q & en_i;
    assign fall_o     = fall_q & en_i;
    assign busy_o     = (state_q == StVerify);
    assign edge_cnt_o = edge_cnt_q;

endmodule

// File: tb/tb_debounce_edge.sv
// Self-checking bench for debounce_edge. Three instances: defaults (u0),
// STABLE_CNT=2/CNT_W=2 (u1) and STABLE_CNT=1 (u2). Expected rise/fall pulses are
// queued with the edge number they must appear on; a negedge monitor pops them.
module tb_debounce_edge;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] en, din, clr;
    logic [2:0] dout_w, doutb_w, rise_w, fall_w, busy_w;
    logic [7:0] ec0, ec2;
    logic [1:0] ec1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int cyc;
        bit up;
    } ev_t;

    ev_t exp_q[3][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    debounce_edge u0 (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en[0]), .din_i(din[0]), .cnt_clr_i(clr[0]),
        .dout_o(dout_w[0]), .dout_bar_o(doutb_w[0]), .rise_o(rise_w[0]), .fall_o(fall_w[0]),
        .busy_o(busy_w[0]), .edge_cnt_o(ec0)
    );

    debounce_edge #(.STABLE_CNT(2), .CNT_W(2)) u1 (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en[1]), .din_i(din[1]), .cnt_clr_i(clr[1]),
        .dout_o(dout_w[1]), .dout_bar_o(doutb_w[1]), .rise_o(rise_w[1]), .fall_o(fall_w[1]),
        .busy_o(busy_w[1]), .edge_cnt_o(ec1)
    );

    debounce_edge #(.STABLE_CNT(1)) u2 (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en[2]), .din_i(din[2]), .cnt_clr_i(clr[2]),
        .dout_o(dout_w[2]), .dout_bar_o(doutb_w[2]), .rise_o(rise_w[2]), .fall_o(fall_w[2]),
        .busy_o(busy_w[2]), .edge_cnt_o(ec2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 2 time units past the edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Expect a pulse on instance k after edge number c.
    task automatic expect_pulse(input int k, input int c, input bit up);
        ev_t e;
        e.cyc = c;
        e.up  = up;
        exp_q[k].push_back(e);
    endtask

    // Scoreboard monitor: every pulse must match the queue head; a head whose edge
    // has passed without a pulse is reported as missing.
    always @(negedge clk) begin
        ev_t ev;
        for (int k = 0; k < 3; k++) begin
            if (rise_w[k] || fall_w[k]) begin
                total++;
                assert (exp_q[k].size() != 0) else begin
                    bad++;
                    $error("FAIL pulse_unexpected u%0d cyc=%0d rise=%0b fall=%0b expected none",
                           k, cyc, rise_w[k], fall_w[k]);
                end
                if (exp_q[k].size() != 0) begin
                    ev = exp_q[k].pop_front();
                    total++;
                    assert (cyc == ev.cyc && rise_w[k] === ev.up && fall_w[k] === !ev.up) else begin
                        bad++;
                        $error("FAIL pulse u%0d observed cyc=%0d rise=%0b fall=%0b expected cyc=%0d up=%0b",
                               k, cyc, rise_w[k], fall_w[k], ev.cyc, ev.up);
                    end
                end
            end else if (exp_q[k].size() != 0 && exp_q[k][0].cyc <= cyc) begin
                ev = exp_q[k].pop_front();
                total++;
                bad++;
                $error("FAIL pulse_missing u%0d observed none at cyc=%0d expected cyc=%0d up=%0b",
                       k, cyc, ev.cyc, ev.up);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        rst_n = 1'b0;
        en    = 3'b110;
        din   = 3'b001;
        clr   = 3'b000;

        // Reset holds everything at reset values even with din=1.
        tick(5);
        chk("rst_dout", dout_w[0], 1'b0);
        chk("rst_dout_bar", doutb_w[0], 1'b1);
        chk("rst_edge_cnt", ec0, 8'd0);
        chk("rst_busy", busy_w[0], 1'b0);

        // Release: dout follows 6 edges later.
        rst_n = 1'b1;
        en[0] = 1'b1;
        t = cyc;
        expect_pulse(0, t + 6, 1'b1);
        tick(5);
        chk("rel_dout_early", dout_w[0], 1'b0);
        chk("rel_busy", busy_w[0], 1'b1);
        tick(1);
        chk("rel_dout", dout_w[0], 1'b1);
        chk("rel_cnt", ec0, 8'd1);
        chk("rel_busy_done", busy_w[0], 1'b0);

        // Back to 0.
        din[0] = 1'b0;
        t = cyc;
        expect_pulse(0, t + 6, 1'b0);
        tick(6);
        chk("fall_dout", dout_w[0], 1'b0);
        chk("fall_dout_bar", doutb_w[0], 1'b1);
        chk("fall_cnt", ec0, 8'd2);

        // Glitch of 3 cycles is rejected.
        din[0] = 1'b1;
        tick(3);
        din[0] = 1'b0;
        chk("glitch_busy", busy_w[0], 1'b1);
        tick(3);
        chk("glitch_busy_done", busy_w[0], 1'b0);
        chk("glitch_dout", dout_w[0], 1'b0);
        chk("glitch_cnt", ec0, 8'd2);
        tick(4);

        // Held step is accepted exactly 6 edges after it is first sampled.
        din[0] = 1'b1;
        t = cyc;
        expect_pulse(0, t + 6, 1'b1);
        tick(6);
        chk("step_dout", dout_w[0], 1'b1);
        chk("step_cnt", ec0, 8'd3);
        din[0] = 1'b0;
        t = cyc;
        expect_pulse(0, t + 6, 1'b0);
        tick(6);
        chk("step_fall_cnt", ec0, 8'd4);

        // Enable freeze after two VERIFY cycles.
        din[0] = 1'b1;
        tick(4);
        en[0] = 1'b0;
        tick(10);
        chk("freeze_busy", busy_w[0], 1'b1);
        chk("freeze_dout", dout_w[0], 1'b0);
        en[0] = 1'b1;
        t = cyc;
        expect_pulse(0, t + 2, 1'b1);
        tick(1);
        chk("unfreeze_dout_early", dout_w[0], 1'b0);
        tick(1);
        chk("unfreeze_dout", dout_w[0], 1'b1);
        chk("unfreeze_cnt", ec0, 8'd5);

        // Toggle train on u1: latency 4, counter saturates at 3.
        for (int i = 1; i <= 4; i++) begin
            din[1] = ~din[1];
            t = cyc;
            expect_pulse(1, t + 4, din[1]);
            tick(4);
            chk($sformatf("train_dout_%0d", i), dout_w[1], din[1]);
            chk($sformatf("train_cnt_%0d", i), ec1, (i > 3) ? 2'd3 : 2'(i));
        end
        // Clear coinciding with an increment wins.
        din[1] = ~din[1];
        t = cyc;
        expect_pulse(1, t + 4, din[1]);
        tick(3);
        clr[1] = 1'b1;
        tick(1);
        clr[1] = 1'b0;
        chk("clr_cnt", ec1, 2'd0);
        chk("clr_dout", dout_w[1], din[1]);
        din[1] = ~din[1];
        t = cyc;
        expect_pulse(1, t + 4, din[1]);
        tick(4);
        chk("post_clr_cnt", ec1, 2'd1);

        // STABLE_CNT=1: SYNC_STAGES+1 latency, never busy.
        din[2] = 1'b1;
        t = cyc;
        expect_pulse(2, t + 3, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk($sformatf("sc1_busy_r%0d", i), busy_w[2], 1'b0);
            chk($sformatf("sc1_dout_r%0d", i), dout_w[2], (i == 2) ? 1'b1 : 1'b0);
        end
        din[2] = 1'b0;
        t = cyc;
        expect_pulse(2, t + 3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk($sformatf("sc1_busy_f%0d", i), busy_w[2], 1'b0);
            chk($sformatf("sc1_dout_f%0d", i), dout_w[2], (i == 2) ? 1'b0 : 1'b1);
        end
        chk("sc1_cnt", ec2, 8'd2);

        // Reset pulse mid-VERIFY discards the pending change with no pulse.
        din[0] = 1'b0;
        tick(4);
        chk("mid_busy", busy_w[0], 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_dout", dout_w[0], 1'b0);
        chk("mid_rst_dout_bar", doutb_w[0], 1'b1);
        chk("mid_rst_busy", busy_w[0], 1'b0);
        chk("mid_rst_cnt", ec0, 8'd0);
        chk("mid_rst_pulses", {rise_w[0], fall_w[0]}, 2'b00);
        rst_n = 1'b1;
        tick(8);
        chk("post_rst_dout", dout_w[0], 1'b0);
        chk("post_rst_busy", busy_w[0], 1'b0);
        chk("post_rst_cnt", ec0, 8'd0);

        tick(2);
        chk("q_empty0", exp_q[0].size(), 0);
        chk("q_empty1", exp_q[1].size(), 0);
        chk("q_empty2", exp_q[2].size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
